// File: rtl/mux_arb_reg_pkg.sv
// Shared definitions for the mux_arb_reg channel selector: mode encodings and
// the ceiling-log2 helper used to size channel indices.
package mux_arb_reg_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_arb_reg_rr_pick.sv
// Rotated-priority picker: returns the first requester after 'last'.
// The scan wraps around and ends at 'last' itself.
module mux_arb_reg_rr_pick
    import mux_arb_reg_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last,
    output logic                gnt_valid,
    output logic [SEL_W-1:0]    gnt_idx
);

    localparam int SW1 = SEL_W + 1;

    logic [SEL_W-1:0]      start;
    logic [2*CHANNELS-1:0] req2;
    logic [CHANNELS-1:0]   rot;
    logic [SEL_W-1:0]      off;
    logic [SEL_W:0]        sum;

    always_comb begin
        start = (last == SEL_W'(CHANNELS - 1)) ? '0 : last + 1'b1;
        req2  = {req, req};
        // Doubled vector shifted right gives the requests rotated so that bit 0 is 'start'.
        rot   = CHANNELS'(req2 >> start);
        gnt_valid = |req;
        off = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= SW1'(CHANNELS)) begin
            sum = sum - SW1'(CHANNELS);
        end
        gnt_idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel selector with fixed or round-robin arbitration feeding a
// one-entry registered output stage with valid/ready handshake.
module mux_arb_reg
    import mux_arb_reg_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    localparam int PAD_N = 1 << SEL_W;

    logic [WIDTH-1:0] chan_data [CHANNELS];
    logic [PAD_N-1:0] valid_ext;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic             load_en;
    logic             xfer;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    logic [SEL_W-1:0] last_q,      last_d;

    mux_arb_reg_rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rr_pick (
        .req       (in_valid),
        .last      (last_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Padding to a power of two keeps an out-of-range sel from indexing past in_valid.
    assign valid_ext = PAD_N'(in_valid);
    assign load_en   = !out_valid_q || out_ready;
    assign xfer      = !reset && gnt_valid && load_en;

    always_comb begin
        if (mode == MODE_RR) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else begin
            gnt_valid = (int'(sel) < CHANNELS) && valid_ext[sel];
            gnt_idx   = sel;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        assign in_ready[gi]  = xfer && (gnt_idx == SEL_W'(gi));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        last_d      = last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_data[gnt_idx];
            out_chan_d  = gnt_idx;
            if (mode == MODE_RR) begin
                last_d = gnt_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            last_q      <= SEL_W'(CHANNELS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: a 4-channel vector table plus a hand-written
// sequence on a 3-channel instance for the out-of-range select and wrap cases.
module tb_mux_arb_reg;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        rst4, mode4, ordy4;
    logic [1:0]  sel4;
    logic [3:0]  vld4, rdy4;
    logic [127:0] data4;
    logic        ov4;
    logic [31:0] od4;
    logic [1:0]  oc4;

    mux_arb_reg #(.WIDTH(32), .CHANNELS(4)) u_dut4 (
        .clk       (clk),
        .reset     (rst4),
        .mode      (mode4),
        .sel       (sel4),
        .in_valid  (vld4),
        .in_data   (data4),
        .in_ready  (rdy4),
        .out_valid (ov4),
        .out_data  (od4),
        .out_chan  (oc4),
        .out_ready (ordy4)
    );

    // 3-channel instance
    logic        rst3, mode3, ordy3;
    logic [1:0]  sel3;
    logic [2:0]  vld3, rdy3;
    logic [95:0] data3;
    logic        ov3;
    logic [31:0] od3;
    logic [1:0]  oc3;

    mux_arb_reg #(.WIDTH(32), .CHANNELS(3)) u_dut3 (
        .clk       (clk),
        .reset     (rst3),
        .mode      (mode3),
        .sel       (sel3),
        .in_valid  (vld3),
        .in_data   (data3),
        .in_ready  (rdy3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_chan  (oc3),
        .out_ready (ordy3)
    );

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  oc;
    } vec_t;

    localparam logic [31:0] D0 = 32'h1000_0000;
    localparam logic [31:0] D1 = 32'h1000_0001;
    localparam logic [31:0] D2 = 32'h1000_0002;
    localparam logic [31:0] D3 = 32'h1000_0003;
    localparam logic [31:0] E0 = 32'h2000_0000;
    localparam logic [31:0] E1 = 32'h2000_0001;
    localparam logic [31:0] E2 = 32'h2000_0002;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    int n_cmp;
    int n_err;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic run4(input vec_t v, input int idx);
        @(negedge clk);
        rst4  = v.rst;
        mode4 = v.mode;
        sel4  = v.sel;
        vld4  = v.vld;
        ordy4 = v.ordy;
        #1;
        chk("dut4.in_ready", idx, 32'(rdy4), 32'(v.rdy));
        @(posedge clk);
        #1;
        chk("dut4.out_valid", idx, 32'(ov4), 32'(v.ov));
        chk("dut4.out_data", idx, od4, v.od);
        chk("dut4.out_chan", idx, 32'(oc4), 32'(v.oc));
        $display("dut4 step %0d: rst=%b mode=%b sel=%0d vld=%b ordy=%b -> rdy=%b ov=%b od=%h oc=%0d",
                 idx, v.rst, v.mode, v.sel, v.vld, v.ordy, rdy4, ov4, od4, oc4);
    endtask

    task automatic run3(input int idx, input logic rst, input logic mode, input logic [1:0] sel,
                        input logic [2:0] vld, input logic ordy, input logic [2:0] rdy,
                        input logic ov, input logic [31:0] od, input logic [1:0] oc);
        @(negedge clk);
        rst3  = rst;
        mode3 = mode;
        sel3  = sel;
        vld3  = vld;
        ordy3 = ordy;
        #1;
        chk("dut3.in_ready", idx, 32'(rdy3), 32'(rdy));
        @(posedge clk);
        #1;
        chk("dut3.out_valid", idx, 32'(ov3), 32'(ov));
        chk("dut3.out_data", idx, od3, od);
        chk("dut3.out_chan", idx, 32'(oc3), 32'(oc));
        $display("dut3 step %0d: rst=%b mode=%b sel=%0d vld=%b ordy=%b -> rdy=%b ov=%b od=%h oc=%0d",
                 idx, rst, mode, sel, vld, ordy, rdy3, ov3, od3, oc3);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst4 = 1'b1; mode4 = 1'b0; sel4 = '0; vld4 = '0; ordy4 = 1'b0;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = '0; vld3 = '0; ordy3 = 1'b0;
        data4 = {D3, D2, D1, D0};
        data3 = {E2, E1, E0};

        //            rst mode sel vld    ordy rdy    ov od  oc
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 32'h0, 2'd0}; // reset, no ready
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0, 1'b0, 32'h0, 2'd0}; // idle
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 4'hF, 1'b1, 4'h4, 1'b1, D2,    2'd2}; // fixed sel=2
        vecs[3]  = '{1'b0, 1'b0, 2'd2, 4'hF, 1'b1, 4'h4, 1'b1, D2,    2'd2};
        vecs[4]  = '{1'b0, 1'b0, 2'd2, 4'hF, 1'b1, 4'h4, 1'b1, D2,    2'd2};
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, D0,    2'd0}; // rr from channel 0
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, D1,    2'd1};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, D2,    2'd2};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, D3,    2'd3};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, D0,    2'd0};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, D1,    2'd1};
        vecs[11] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, D2,    2'd2};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, D3,    2'd3};
        vecs[13] = '{1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 4'h2, 1'b1, D1,    2'd1}; // 1010: ch1 first
        vecs[14] = '{1'b0, 1'b1, 2'd0, 4'hA, 1'b0, 4'h0, 1'b1, D1,    2'd1}; // stall x3
        vecs[15] = '{1'b0, 1'b1, 2'd0, 4'hA, 1'b0, 4'h0, 1'b1, D1,    2'd1};
        vecs[16] = '{1'b0, 1'b1, 2'd0, 4'hA, 1'b0, 4'h0, 1'b1, D1,    2'd1};
        vecs[17] = '{1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 4'h8, 1'b1, D3,    2'd3}; // release: ch3
        vecs[18] = '{1'b0, 1'b1, 2'd0, 4'hA, 1'b1, 4'h2, 1'b1, D1,    2'd1}; // then ch1
        vecs[19] = '{1'b0, 1'b1, 2'd0, 4'h0, 1'b1, 4'h0, 1'b0, D1,    2'd1}; // drain, data holds
        vecs[20] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h4, 1'b1, D2,    2'd2}; // empty stage loads
        vecs[21] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, D2,    2'd2}; // stalled
        vecs[22] = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b0, 32'h0, 2'd0}; // reset drops beat
        vecs[23] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, D0,    2'd0}; // ch0 first again
        vecs[24] = '{1'b0, 1'b0, 2'd1, 4'hD, 1'b1, 4'h0, 1'b0, D0,    2'd0}; // sel'd ch not valid
        vecs[25] = '{1'b0, 1'b0, 2'd3, 4'hD, 1'b1, 4'h8, 1'b1, D3,    2'd3}; // fixed, ptr holds
        vecs[26] = '{1'b0, 1'b1, 2'd0, 4'hD, 1'b1, 4'h4, 1'b1, D2,    2'd2}; // rr resumes after 0

        for (int i = 0; i < NVEC; i++) begin
            run4(vecs[i], i);
        end

        //   idx rst   mode  sel   vld     ordy  rdy     ov    od     oc
        run3(0, 1'b1, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 1'b0, 32'h0, 2'd0);
        run3(1, 1'b0, 1'b0, 2'd1, 3'b111, 1'b0, 3'b010, 1'b1, E1,    2'd1);
        run3(2, 1'b0, 1'b0, 2'd3, 3'b111, 1'b0, 3'b000, 1'b1, E1,    2'd1);
        run3(3, 1'b0, 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, E1,    2'd1);
        run3(4, 1'b0, 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, E1,    2'd1);
        run3(5, 1'b0, 1'b1, 2'd3, 3'b111, 1'b1, 3'b001, 1'b1, E0,    2'd0);
        run3(6, 1'b0, 1'b1, 2'd3, 3'b111, 1'b1, 3'b010, 1'b1, E1,    2'd1);
        run3(7, 1'b0, 1'b1, 2'd3, 3'b111, 1'b1, 3'b100, 1'b1, E2,    2'd2);
        run3(8, 1'b0, 1'b1, 2'd3, 3'b111, 1'b1, 3'b001, 1'b1, E0,    2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
